wb4_to_pi1: RTL
===============

Name: wb4_to_pi1

Overview:
- Wishbone B4 pipelined slave to PerInt (PI1) master bridge; single clock domain.
- Lets a WB4 initiator (external core, debug master) reach PI1-attached peripherals.
- Requests are buffered in a small FIFO and issued one op at a time on PI1.
- Completions are returned as one wb4_ack_o per accepted request.

Parameters:
- ARCHBITSZ, 16, data width in bits; power of 2, at least 16.
- FIFODEPTH, 2, request FIFO entries; power of 2, at least 2.
- Derived: ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).

Ports:
- wb4_clk_i  in  1  clock
- wb4_rst_i  in  1  synchronous active-high reset
- wb4_cyc_i  in  1  WB4 cycle
- wb4_stb_i  in  1  WB4 strobe
- wb4_we_i  in  1  1 = write
- wb4_addr_i  in  ARCHBITSZ  byte address
- wb4_data_i  in  ARCHBITSZ  write data
- wb4_sel_i  in  ARCHBITSZ/8  byte selects
- wb4_stall_o  out  1  request not accepted
- wb4_ack_o  out  1  request completed
- wb4_data_o  out  ARCHBITSZ  read data
- pi1_op_o  out  2  00 NOOP, 01 WR, 10 RD (11 RW never issued)
- pi1_addr_o  out  ADDRBITSZ  word address
- pi1_data_o  out  ARCHBITSZ  write data
- pi1_data_i  in  ARCHBITSZ  result of previous op
- pi1_sel_o  out  ARCHBITSZ/8  byte selects
- pi1_rdy_i  in  1  slave ready

Behaviour:
- Reset values: wb4_ack_o=0, wb4_data_o=0, wb4_stall_o=0, pi1_op_o=NOOP. FIFO is empty and pending=0. Reset mid-operation abandons everything; no ack is produced afterwards for pre-reset requests.
- WB4 accept: a request is accepted at a posedge where cyc_i & stb_i & !stall_o. Accepted requests are pushed into the FIFO as {we, addr_i[ARCHBITSZ-1:clog2(ARCHBITSZ/8)], data_i, sel_i}.
- wb4_stall_o = FIFO full, registered-equivalent. There is no same-cycle push when full, even if a pop occurs in that cycle.
- PI1 drive: combinational from the FIFO head.
  - FIFO non-empty: pi1_op_o = we ? WR : RD, with addr/data/sel taken from the head entry.
  - FIFO empty: pi1_op_o = NOOP; addr/data/sel hold the last head values.
- Issue: an op is taken by the slave at a posedge where pi1_rdy_i=1 and pi1_op_o != NOOP. At that edge the FIFO pops and pending is set.
- Completion: pending=1 and pi1_rdy_i=1 at a posedge completes the outstanding op. On the next cycle wb4_ack_o=1 for exactly 1 cycle and wb4_data_o = pi1_data_i sampled at that edge; this is don't-care for writes but is latched anyway.
- Back-to-back: completion and the next issue occur at the same edge. pending stays 1 and continuous acks are possible. Throughput is 1 op/cycle when pi1_rdy_i stays high.
- Latency: a request accepted at edge N with an empty FIFO is issued at N+1 if rdy. Completion is at N+2 if rdy, and wb4_ack_o is high in the cycle after N+2.
- At most one PI1 op is outstanding. The number of acks always equals the number of accepted requests, unless aborted.
- Abort: if cyc_i=0 at a posedge:
  - FIFO entries not yet issued are flushed, and pi1_op_o is NOOP from the next cycle.
  - An op already issued still completes on PI1, but its ack is suppressed (drop flag).
  - A new cycle's requests may be accepted but are issued only after the dropped op completes.
- Simultaneous push, pop and completion in one cycle: the FIFO count is unchanged and all three actions take effect.
- FIFO pointers wrap modulo FIFODEPTH. Full/empty are tracked with a count register of clog2(FIFODEPTH)+1 bits.

Test Plan:
- Single write, addr=0x0006, data=0xBEEF, sel=2'b11, rdy held 1. Required: pi1_op_o=WR, pi1_addr_o=0x0003, pi1_data_o=0xBEEF for 1 cycle; wb4_ack_o pulses once 3 cycles after acceptance.
- Single read, addr=0x0010, slave returns 0x1234 on completion edge. Required: pi1_op_o=RD, pi1_addr_o=0x0008; wb4_ack_o=1 with wb4_data_o=0x1234.
- Four pipelined reads, rdy=1. Required: 4 consecutive acks returning slave data D0..D3 in order; stall_o=0 throughout.
- Reads while pi1_rdy_i=0 for 10 cycles. Required: stall_o rises after FIFODEPTH accepts, pi1_op_o held stable; after rdy returns, all pending requests are acked in order and stall_o clears.
- Two writes accepted, rdy=0, then cyc_i dropped. Required: neither write issued after the drop and no ack. Variant with the first write in flight: it completes on PI1 with no ack; a following cycle's read is acked with correct data.
- Reset asserted with pending=1 and FIFO count 2. Required: next cycle ack=0, op=NOOP, stall_o=0; no stray ack after reset is released.

Source files
------------

// File: rtl/wb4_to_pi1_if.sv
// wb4_to_pi1_if: Wishbone B4 slave side and PI1 master side signals of the bridge
interface wb4_to_pi1_if #(
  parameter int ARCHBITSZ = 16
);
  localparam int SELW = ARCHBITSZ / 8;
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(SELW);
  logic wb4_cyc_i;
  logic wb4_stb_i;
  logic wb4_we_i;
  logic [ARCHBITSZ-1:0] wb4_addr_i;
  logic [ARCHBITSZ-1:0] wb4_data_i;
  logic [SELW-1:0] wb4_sel_i;
  logic wb4_stall_o;
  logic wb4_ack_o;
  logic [ARCHBITSZ-1:0] wb4_data_o;
  logic [1:0] pi1_op_o;
  logic [ADDRBITSZ-1:0] pi1_addr_o;
  logic [ARCHBITSZ-1:0] pi1_data_o;
  logic [ARCHBITSZ-1:0] pi1_data_i;
  logic [SELW-1:0] pi1_sel_o;
  logic pi1_rdy_i;
  modport slave (
    input wb4_cyc_i, wb4_stb_i, wb4_we_i, wb4_addr_i, wb4_data_i, wb4_sel_i, pi1_data_i, pi1_rdy_i,
    output wb4_stall_o, wb4_ack_o, wb4_data_o, pi1_op_o, pi1_addr_o, pi1_data_o, pi1_sel_o
  );
  modport master (
    output wb4_cyc_i, wb4_stb_i, wb4_we_i, wb4_addr_i, wb4_data_i, wb4_sel_i, pi1_data_i, pi1_rdy_i,
    input wb4_stall_o, wb4_ack_o, wb4_data_o, pi1_op_o, pi1_addr_o, pi1_data_o, pi1_sel_o
  );
endinterface

// File: rtl/wb4_to_pi1.sv
// wb4_to_pi1: Wishbone B4 pipelined slave to PI1 master bridge with a small request FIFO
module wb4_to_pi1 #(
  parameter int ARCHBITSZ = 16,
  parameter int FIFODEPTH = 2
) (
  input logic wb4_clk_i,
  input logic wb4_rst_i,
  wb4_to_pi1_if.slave bus
);
  localparam int SELW = ARCHBITSZ / 8;
  localparam int AB = $clog2(SELW);
  localparam int ADDRBITSZ = ARCHBITSZ - AB;
  localparam int AW = $clog2(FIFODEPTH);
  typedef struct packed {
    logic we;
    logic [ADDRBITSZ-1:0] addr;
    logic [ARCHBITSZ-1:0] data;
    logic [SELW-1:0] sel;
  } req_t;
  req_t mem [FIFODEPTH];
  req_t head, last, cur;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic pending, drop, empty, full, push, pop, comp, pending_n, ack;
  logic [ARCHBITSZ-1:0] rdata;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(FIFODEPTH);
  assign head = mem[rp];
  assign cur = empty ? last : head;
  assign push = bus.wb4_cyc_i & bus.wb4_stb_i & !full;
  // a dropped op must finish before anything new goes out
  assign pop = bus.pi1_rdy_i & !empty & !drop;
  assign comp = pending & bus.pi1_rdy_i;
  assign pending_n = pop | (pending & !bus.pi1_rdy_i);
  assign bus.wb4_stall_o = full;
  assign bus.wb4_ack_o = ack;
  assign bus.wb4_data_o = rdata;
  assign bus.pi1_op_o = (empty | drop) ? 2'b00 : head.we ? 2'b01 : 2'b10;
  assign bus.pi1_addr_o = cur.addr;
  assign bus.pi1_data_o = cur.data;
  assign bus.pi1_sel_o = cur.sel;
  always_ff @(posedge wb4_clk_i) begin
    if (push) mem[wp] <= {bus.wb4_we_i, bus.wb4_addr_i[ARCHBITSZ-1:AB], bus.wb4_data_i, bus.wb4_sel_i};
  end
  always_ff @(posedge wb4_clk_i) begin
    if (wb4_rst_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      pending <= 1'b0;
      drop <= 1'b0;
      last <= '0;
      ack <= 1'b0;
      rdata <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= bus.wb4_cyc_i ? rp + AW'(pop) : wp;
      cnt <= bus.wb4_cyc_i ? cnt + (AW+1)'(push) - (AW+1)'(pop) : '0;
      last <= cur;
      pending <= pending_n;
      // whatever is outstanding across an abort completes silently
      drop <= bus.wb4_cyc_i ? drop & !comp : pending_n;
      ack <= comp & !drop & bus.wb4_cyc_i;
      rdata <= comp ? bus.pi1_data_i : rdata;
    end
  end
endmodule
